i_ddr_align_ctrl: RTL and testbench

I_DDR_ALIGN_CTRL -- requirements
Module: i_ddr_align_ctrl

---
 rtl/i_ddr_align_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_i_ddr_align_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i_ddr_align_ctrl.sv
// Purpose : word-boundary alignment / bitslip controller behind a 2-bit I_DDR input register.
// Latency : one word is assembled every 4 cycles; DATA_OUT/DATA_VALID appear the cycle after the word's last pair.
// Backpress: none, the link free-runs; EN_IN=0 drops back to IDLE and R=1 resets everything.
//
// Ports:
//   C, R           clock and synchronous active-high reset
//   EN_IN          level enable; 0 returns to IDLE from any state
//   DDR_Q          I_DDR Q: bit1 = posedge sample (earlier in time), bit0 = negedge sample
//   TRAIN_PATTERN  training word that a completed word is compared against
//   DDR_E          I_DDR register enable
//   DATA_OUT       assembled word; first-received pair lands in [7:6]
//   DATA_VALID     one-cycle strobe per word, only while LOCKED
//   LOCKED         high while locked
//   ALIGN_ERR      high while in FAIL (alignment gave up)
//   SLIP_CNT       word-boundary offset in pairs, mod 4
module i_ddr_align_ctrl #(
  parameter int unsigned MATCH_COUNT  = 4,   // consecutive matches needed to lock (1..15)
  parameter int unsigned MAX_ATTEMPTS = 16   // mismatched words tolerated before FAIL (1..255)
) (
  input  logic       C,
  input  logic       R,
  input  logic       EN_IN,
  input  logic [1:0] DDR_Q,
  input  logic [7:0] TRAIN_PATTERN,
  output logic       DDR_E,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID,
  output logic       LOCKED,
  output logic       ALIGN_ERR,
  output logic [1:0] SLIP_CNT
);

  localparam logic [3:0] MATCH_LIM = 4'(MATCH_COUNT);
  localparam logic [7:0] ATT_LIM   = 8'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SEARCH,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] pair_cnt, pair_nxt;
  logic [3:0] match_cnt, match_nxt;
  logic [7:0] att_cnt, att_nxt;
  logic       flush_cnt, flush_nxt;
  logic [1:0] slip_nxt;
  logic [5:0] sr, sr_nxt;          // only the 6 most recent bits feed a completed word
  logic [7:0] dout_nxt;
  logic       dv_nxt;

  logic [7:0] word;
  logic       word_done;
  logic [7:0] att_inc;
  logic [3:0] match_inc;
  logic       give_up;

  assign word      = {sr, DDR_Q};
  assign word_done = (pair_cnt == 2'd3);
  assign att_inc   = att_cnt + 8'd1;
  assign match_inc = match_cnt + 4'd1;
  assign give_up   = (att_inc == ATT_LIM);

  always_comb begin
    state_nxt = state;
    pair_nxt  = pair_cnt;
    match_nxt = match_cnt;
    att_nxt   = att_cnt;
    flush_nxt = flush_cnt;
    slip_nxt  = SLIP_CNT;
    sr_nxt    = sr;
    dout_nxt  = DATA_OUT;
    dv_nxt    = 1'b0;

    if ((state != ST_IDLE) && !EN_IN) begin
      // Disable wins over everything, including a word completing this cycle.
      // The slip offset is kept so a re-enable starts from the last boundary.
      state_nxt = ST_IDLE;
      pair_nxt  = 2'd0;
      match_nxt = 4'd0;
      att_nxt   = 8'd0;
      flush_nxt = 1'b0;
      sr_nxt    = 6'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (EN_IN) begin
            state_nxt = ST_FLUSH;
            flush_nxt = 1'b0;
          end
        end

        // Two cycles to let stale data drain out of the I_DDR register.
        ST_FLUSH: begin
          if (flush_cnt) begin
            state_nxt = ST_SEARCH;
            flush_nxt = 1'b0;
            pair_nxt  = 2'd0;
            match_nxt = 4'd0;
            att_nxt   = 8'd0;
          end else begin
            flush_nxt = 1'b1;
          end
        end

        ST_SEARCH, ST_CHECK: begin
          sr_nxt   = word[5:0];
          pair_nxt = pair_cnt + 2'd1;
          if (word_done) begin
            if (word == TRAIN_PATTERN) begin
              match_nxt = (state == ST_SEARCH) ? 4'd1 : match_inc;
              state_nxt = (match_nxt == MATCH_LIM) ? ST_LOCKED : ST_CHECK;
            end else begin
              match_nxt = 4'd0;
              att_nxt   = att_inc;
              if (give_up) begin
                state_nxt = ST_FAIL;
              end else begin
                // Bitslip: the pair counter stays at 3, so the next cycle
                // completes a word whose boundary sits one pair later.
                state_nxt = ST_SEARCH;
                slip_nxt  = SLIP_CNT + 2'd1;
                pair_nxt  = pair_cnt;
              end
            end
          end
        end

        ST_LOCKED: begin
          sr_nxt   = word[5:0];
          pair_nxt = pair_cnt + 2'd1;
          if (word_done) begin
            dout_nxt = word;
            dv_nxt   = 1'b1;
          end
        end

        ST_FAIL: begin
          // Parked until EN_IN drops.
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state      <= ST_IDLE;
      pair_cnt   <= 2'd0;
      match_cnt  <= 4'd0;
      att_cnt    <= 8'd0;
      flush_cnt  <= 1'b0;
      sr         <= 6'd0;
      SLIP_CNT   <= 2'd0;
      DATA_OUT   <= 8'h00;
      DATA_VALID <= 1'b0;
      DDR_E      <= 1'b0;
      LOCKED     <= 1'b0;
      ALIGN_ERR  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pair_cnt   <= pair_nxt;
      match_cnt  <= match_nxt;
      att_cnt    <= att_nxt;
      flush_cnt  <= flush_nxt;
      sr         <= sr_nxt;
      SLIP_CNT   <= slip_nxt;
      DATA_OUT   <= dout_nxt;
      DATA_VALID <= dv_nxt;
      // Status outputs are registered copies of the next-state decode.
      DDR_E      <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAIL);
      LOCKED     <= (state_nxt == ST_LOCKED);
      ALIGN_ERR  <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_i_ddr_align_ctrl.sv
// Purpose : directed self-checking bench for i_ddr_align_ctrl with default parameters.
// Latency : t counts clock edges since reset release; the first SEARCH pair is sampled on edge 4.
// Backpress: n/a; the stream free-runs with a per-scenario pair offset and optional corrupt word.
module tb_i_ddr_align_ctrl;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       EN_IN = 1'b0;
  logic [1:0] DDR_Q = 2'b00;
  logic [7:0] TRAIN_PATTERN = 8'hA5;
  logic       DDR_E;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       LOCKED;
  logic       ALIGN_ERR;
  logic [1:0] SLIP_CNT;

  int n_chk = 0;
  int n_err = 0;

  // Stream generator state
  logic [7:0] pat = 8'hA5;
  int offset = 0;
  int sidx = 0;
  int corrupt_at = -100;
  int t = 0;

  i_ddr_align_ctrl dut (
    .C             (C),
    .R             (R),
    .EN_IN         (EN_IN),
    .DDR_Q         (DDR_Q),
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .DDR_E         (DDR_E),
    .DATA_OUT      (DATA_OUT),
    .DATA_VALID    (DATA_VALID),
    .LOCKED        (LOCKED),
    .ALIGN_ERR     (ALIGN_ERR),
    .SLIP_CNT      (SLIP_CNT)
  );

  always #5 C = ~C;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Drive one pair, take one edge, then sample 1 time unit after the edge.
  // sidx 0 is the first pair seen in SEARCH; offset k delays the word start by k pairs.
  task automatic tick();
    int k;
    k = (sidx - offset) & 3;
    if (sidx >= corrupt_at && sidx < corrupt_at + 4)
      DDR_Q = 2'b00;
    else
      DDR_Q = 2'((pat >> (6 - 2 * k)) & 8'h03);
    @(posedge C);
    #1;
    sidx++;
    t++;
  endtask

  task automatic run_to(input int k);
    while (t < k) tick();
  endtask

  // Reset for one edge, then release with EN_IN=1; edge 1 enters FLUSH.
  task automatic start(input logic [7:0] p, input int off);
    R = 1'b1;
    EN_IN = 1'b0;
    tick();
    R = 1'b0;
    EN_IN = 1'b1;
    pat = p;
    offset = off;
    corrupt_at = -100;
    sidx = -3;
    t = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_eq({tag, "_ddr_e"},  32'(DDR_E), 32'd0);
    chk_eq({tag, "_dout"},   32'(DATA_OUT), 32'h00);
    chk_eq({tag, "_dv"},     32'(DATA_VALID), 32'd0);
    chk_eq({tag, "_locked"}, 32'(LOCKED), 32'd0);
    chk_eq({tag, "_err"},    32'(ALIGN_ERR), 32'd0);
    chk_eq({tag, "_slip"},   32'(SLIP_CNT), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with EN_IN high: reset must dominate.
    R = 1'b1;
    EN_IN = 1'b1;
    tick();
    tick();
    chk_reset_outs("rst");

    // Aligned stream: lock on edge 19, words every 4 cycles after that.
    start(8'hA5, 0);
    tick();
    chk_eq("flush_ddr_e", 32'(DDR_E), 32'd1);
    run_to(18);
    chk_eq("al_not_locked", 32'(LOCKED), 32'd0);
    run_to(19);
    chk_eq("al_locked", 32'(LOCKED), 32'd1);
    chk_eq("al_slip", 32'(SLIP_CNT), 32'd0);
    run_to(22);
    chk_eq("al_dv_early", 32'(DATA_VALID), 32'd0);
    run_to(23);
    chk_eq("al_dv1", 32'(DATA_VALID), 32'd1);
    chk_eq("al_dout1", 32'(DATA_OUT), 32'hA5);
    tick();
    chk_eq("al_dv_gap", 32'(DATA_VALID), 32'd0);
    chk_eq("al_dout_hold", 32'(DATA_OUT), 32'hA5);
    run_to(27);
    chk_eq("al_dv2", 32'(DATA_VALID), 32'd1);

    // Reset mid-word while locked, then relock from FLUSH.
    tick();
    R = 1'b1;
    tick();
    chk_reset_outs("rst_lk");
    R = 1'b0;
    sidx = -3;
    t = 0;
    tick();
    chk_eq("rst_lk_dv_after", 32'(DATA_VALID), 32'd0);
    chk_eq("rst_lk_flush", 32'(DDR_E), 32'd1);
    run_to(19);
    chk_eq("rst_lk_relock", 32'(LOCKED), 32'd1);
    run_to(23);
    chk_eq("rst_lk_dv", 32'(DATA_VALID), 32'd1);
    chk_eq("rst_lk_dout", 32'(DATA_OUT), 32'hA5);

    // Offset by one pair: one slip on edge 7, lock on edge 20.
    start(8'hA5, 1);
    run_to(7);
    chk_eq("off1_slip_e7", 32'(SLIP_CNT), 32'd1);
    run_to(19);
    chk_eq("off1_not_locked", 32'(LOCKED), 32'd0);
    run_to(20);
    chk_eq("off1_locked", 32'(LOCKED), 32'd1);
    chk_eq("off1_slip", 32'(SLIP_CNT), 32'd1);
    // Disable on the cycle a word completes (edge 24).
    run_to(23);
    EN_IN = 1'b0;
    tick();
    chk_eq("dis_dv", 32'(DATA_VALID), 32'd0);
    chk_eq("dis_locked", 32'(LOCKED), 32'd0);
    chk_eq("dis_ddr_e", 32'(DDR_E), 32'd0);
    chk_eq("dis_slip", 32'(SLIP_CNT), 32'd1);
    chk_eq("dis_dout", 32'(DATA_OUT), 32'h00);
    tick();
    chk_eq("dis_dv_next", 32'(DATA_VALID), 32'd0);

    // Offset by three pairs: three slips, lock on edge 22.
    start(8'hA5, 3);
    run_to(21);
    chk_eq("off3_not_locked", 32'(LOCKED), 32'd0);
    run_to(22);
    chk_eq("off3_locked", 32'(LOCKED), 32'd1);
    chk_eq("off3_slip", 32'(SLIP_CNT), 32'd3);

    // Constant zero stream: 16th mismatch on edge 22 -> FAIL after 15 slips.
    start(8'h00, 0);
    run_to(21);
    chk_eq("zero_err_early", 32'(ALIGN_ERR), 32'd0);
    chk_eq("zero_ddr_e_early", 32'(DDR_E), 32'd1);
    run_to(22);
    chk_eq("zero_err", 32'(ALIGN_ERR), 32'd1);
    chk_eq("zero_ddr_e", 32'(DDR_E), 32'd0);
    chk_eq("zero_slip", 32'(SLIP_CNT), 32'd3);
    run_to(30);
    chk_eq("zero_err_hold", 32'(ALIGN_ERR), 32'd1);
    EN_IN = 1'b0;
    tick();
    chk_eq("zero_idle_err", 32'(ALIGN_ERR), 32'd0);
    chk_eq("zero_idle_ddr_e", 32'(DDR_E), 32'd0);
    chk_eq("zero_idle_slip", 32'(SLIP_CNT), 32'd3);

    // Corrupt third training word while in CHECK: re-search, lock on edge 31.
    start(8'hA5, 0);
    corrupt_at = 8;
    run_to(11);
    chk_eq("cor_mc2_not_locked", 32'(LOCKED), 32'd0);
    run_to(15);
    chk_eq("cor_slip1", 32'(SLIP_CNT), 32'd1);
    chk_eq("cor_not_locked", 32'(LOCKED), 32'd0);
    run_to(19);
    chk_eq("cor_no_early_lock", 32'(LOCKED), 32'd0);
    run_to(30);
    chk_eq("cor_not_locked_30", 32'(LOCKED), 32'd0);
    run_to(31);
    chk_eq("cor_locked", 32'(LOCKED), 32'd1);
    chk_eq("cor_slip_final", 32'(SLIP_CNT), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
